// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among byte-stream requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic                   busy_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [NUM_REQ-1:0]  gnt_q,      gnt_d;
    logic [IW-1:0]       idx_q,      idx_d;
    logic [IW-1:0]       rr_q,       rr_d;
    logic [BW-1:0]       beat_q,     beat_d;
    logic [GW-1:0]       gap_q,      gap_d;
    logic                last_q,     last_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_valid_q, tx_valid_d;

    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       next_idx;
    logic                cur_valid;
    logic                cur_last;
    logic [7:0]          cur_data;
    logic                xfer;

    assign cur_valid = req_valid_i[idx_q];
    assign cur_last  = req_last_i[idx_q];
    assign cur_data  = req_data_i[{idx_q, 3'b000} +: 8];
    assign next_idx  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    // A byte moves only while granted, the requester offers one and the transmitter is idle
    assign xfer        = (state_q == S_LOAD) && cur_valid && tx_ready_i;
    assign req_ready_o = xfer ? gnt_q : '0;

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign gnt_o      = gnt_q;
    assign busy_o     = (state_q != S_IDLE);

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IW'((int'(rr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant / byte-issue / handshake sequencing
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found && tx_ready_i) begin
                    state_d         = S_LOAD;
                    idx_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    beat_d          = '0;
                    gap_d           = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    tx_data_d  = cur_data;
                    tx_valid_d = 1'b1;
                    // Hitting the burst limit ends the grant exactly like a last byte
                    last_d     = cur_last | (beat_q == BURST_END);
                    beat_d     = beat_q + 1'b1;
                    gap_d      = '0;
                    state_d    = S_WAIT_LO;
                end else if (!cur_valid) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        rr_d    = next_idx;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            S_WAIT_LO: begin
                // Ready may still read high in the pulse cycle; wait for the frame to start
                if (!tx_ready_i) begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_ready_i) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        rr_d    = next_idx;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            rr_q       <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            rr_q       <= rr_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 16;
    localparam int GT = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   gnt;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .GAP_TIMEOUT(GT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .gnt_o       (gnt),
        .busy_o      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // requester byte queues {last,data}, expected per-requester streams, uart model
    logic [8:0]  rq [N][$];
    logic [7:0]  xs [N][$];
    logic [N-1:0] hold = '0;
    int          hold_cnt [N];
    int          frame_len = 10;
    int          busy_cnt  = 0;
    logic        force_lo  = 1'b0;
    logic [N-1:0] fired;
    logic        pulse_seen;
    int          g2_cycles = 0;
    logic        rdy_seen  = 1'b0;
    logic [11:0] plog [$];

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (rq[k].size() > 0) && !hold[k];
            if (rq[k].size() > 0) {req_last[k], req_data[8*k +: 8]} = rq[k][0];
            else                  {req_last[k], req_data[8*k +: 8]} = 9'd0;
        end
        tx_ready = (busy_cnt == 0) && !force_lo;
    endtask

    task automatic step();
        @(negedge clk);
        fired      = req_ready;
        pulse_seen = tx_valid;
        if (gnt == 4'b0100) g2_cycles++;
        if (|req_ready) rdy_seen = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (fired[k]) void'(rq[k].pop_front());
        if (busy_cnt > 0) busy_cnt--;
        if (pulse_seen) busy_cnt = frame_len;
        drive_inputs();
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input logic l);
        rq[k].push_back({l, d});
        xs[k].push_back(d);
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset(input logic ready_low);
        rst_n    = 1'b0;
        force_lo = ready_low;
        busy_cnt = 0;
        hold     = '0;
        for (int k = 0; k < N; k++) begin
            rq[k].delete();
            xs[k].delete();
            hold_cnt[k] = 0;
        end
        drive_inputs();
        step();
        step();
        rst_n = 1'b1;
        drive_inputs();
        plog.delete();
        g2_cycles = 0;
        rdy_seen  = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        hold = '0;
        for (int k = 0; k < N; k++) hold_cnt[k] = 0;
        drive_inputs();
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = all_empty() && (gnt == '0) && !busy && (busy_cnt == 0);
        end
        check({name, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string name, input logic [11:0] exp [$]);
        check({name, "_count"}, plog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < plog.size(); i++)
            check({name, "_entry"}, plog[i], exp[i]);
    endtask

    // Reference model: owner/pointer/burst/gap bookkeeping at the handshake level
    int          m_owner = -1;
    int          m_rr    = 0;
    int          m_gap   = 0;
    int          m_beats = 0;
    bit          m_loading = 0, m_saw_low = 0, m_done = 0, m_txv = 0;
    logic [7:0]  m_data = '0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] er;
        bit           found;
        int           k;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        er = '0;
        if (m_owner >= 0 && m_loading && req_valid[m_owner] && tx_ready) er[m_owner] = 1'b1;
        check("gnt_o", gnt, eg);
        check("busy_o", busy, 32'(m_owner >= 0));
        check("tx_valid_o", tx_valid, m_txv);
        check("req_ready_o", req_ready, er);
        if (m_txv) check("tx_data_o", tx_data, m_data);
        if (tx_valid === 1'b1) begin
            plog.push_back({gnt, tx_data});
            check("pulse_ready_high", tx_ready, 1);
            for (int j = 0; j < N; j++) begin
                if (gnt[j] === 1'b1) begin
                    if (xs[j].size() == 0) check("stream_extra", 32'(j), 32'hffff);
                    else                   check("stream_data", tx_data, xs[j].pop_front());
                end
            end
        end
        m_txv = 0;
        if (rst_n !== 1'b1) begin
            m_owner = -1; m_rr = 0; m_gap = 0; m_beats = 0;
            m_loading = 0; m_saw_low = 0; m_done = 0;
        end else if (m_owner < 0) begin
            if (|req_valid && tx_ready) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    k = (m_rr + i) % N;
                    if (!found && req_valid[k]) begin
                        found   = 1;
                        m_owner = k;
                    end
                end
                m_loading = 1; m_gap = 0; m_beats = 0;
            end
        end else if (m_loading) begin
            if (req_valid[m_owner] && tx_ready) begin
                m_txv     = 1;
                m_data    = req_data[8*m_owner +: 8];
                m_beats   = m_beats + 1;
                m_done    = req_last[m_owner] || (m_beats == MB);
                m_loading = 0;
                m_saw_low = 0;
                m_gap     = 0;
            end else if (!req_valid[m_owner]) begin
                m_gap = m_gap + 1;
                if (m_gap == GT) begin
                    m_rr      = (m_owner + 1) % N;
                    m_owner   = -1;
                    m_loading = 0;
                end
            end
        end else begin
            if (!m_saw_low) begin
                if (!tx_ready) m_saw_low = 1;
            end else if (tx_ready) begin
                if (m_done) begin
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_loading = 1;
                    m_gap     = 0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp [$];
        bit          ok;

        // reset state
        do_reset(1'b0);
        check("reset_outputs", {gnt, busy, tx_valid, req_ready, tx_data}, 32'd0);

        // 1: three-byte packet from req0 over a slow transmitter
        frame_len = 100;
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        drive_inputs();
        drain("t1", 1000);
        exp = '{12'h141, 12'h142, 12'h143};
        check_log("t1", exp);
        check("t1_idle", {gnt, busy}, 32'd0);

        // 2: simultaneous requests follow the pointer
        do_reset(1'b0);
        frame_len = 3;
        push_byte(1, 8'h51, 1'b1);
        push_byte(2, 8'h62, 1'b1);
        drive_inputs();
        drain("t2a", 200);
        push_byte(0, 8'h70, 1'b1);
        push_byte(3, 8'h83, 1'b1);
        drive_inputs();
        drain("t2b", 200);
        exp = '{12'h251, 12'h462, 12'h883, 12'h170};
        check_log("t2", exp);

        // 3: burst limit forces rotation mid-stream
        do_reset(1'b0);
        frame_len = 2;
        for (int i = 0; i < 20; i++) push_byte(0, 8'(i), 1'b0);
        push_byte(3, 8'hA0, 1'b0);
        push_byte(3, 8'hA1, 1'b1);
        drive_inputs();
        drain("t3", 2000);
        exp.delete();
        for (int i = 0; i < 16; i++) exp.push_back({4'b0001, 8'(i)});
        exp.push_back(12'h8A0);
        exp.push_back(12'h8A1);
        for (int i = 16; i < 20; i++) exp.push_back({4'b0001, 8'(i)});
        check_log("t3", exp);

        // 4: idle gap revokes req2's grant, pending req0 wins next
        do_reset(1'b0);
        frame_len = 2;
        push_byte(2, 8'h22, 1'b0);
        drive_inputs();
        for (int c = 0; c < 50 && plog.size() == 0; c++) step();
        check("t4_first_pulse", plog.size(), 1);
        push_byte(0, 8'h0A, 1'b1);
        drive_inputs();
        drain("t4", 500);
        exp = '{12'h422, 12'h10A};
        check_log("t4", exp);
        check("t4_grant_cycles", g2_cycles, 69);

        // 5: reset while waiting for the frame to finish
        do_reset(1'b0);
        frame_len = 10;
        push_byte(0, 8'h51, 1'b0);
        push_byte(0, 8'h52, 1'b0);
        push_byte(0, 8'h53, 1'b1);
        drive_inputs();
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            step();
            ok = (busy_cnt != 0);
        end
        check("t5_frame_started", 32'(ok), 1);
        step();
        rst_n    = 1'b0;
        force_lo = 1'b1;
        drive_inputs();
        step();
        rst_n = 1'b1;
        drive_inputs();
        check("t5_reset_outputs", {gnt, busy, tx_valid, req_ready, tx_data}, 32'd0);
        for (int c = 0; c < 15; c++) step();
        check("t5_no_pulse", plog.size(), 1);
        check("t5_no_grant", {gnt, busy}, 32'd0);
        force_lo = 1'b0;
        drain("t5", 500);
        exp = '{12'h151, 12'h152, 12'h153};
        check_log("t5", exp);

        // 6: transmitter busy from the start holds everything back
        do_reset(1'b1);
        push_byte(0, 8'h66, 1'b1);
        drive_inputs();
        for (int c = 0; c < 20; c++) step();
        check("t6_no_ready", 32'(rdy_seen), 0);
        check("t6_no_pulse", plog.size(), 0);
        force_lo = 1'b0;
        drain("t6", 200);
        exp = '{12'h166};
        check_log("t6", exp);

        // randomized traffic against the model
        do_reset(1'b0);
        for (int c = 0; c < 4000; c++) begin
            frame_len = $urandom_range(1, 8);
            for (int k = 0; k < N; k++) begin
                if (rq[k].size() < 8 && $urandom_range(0, 19) == 0) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++)
                        push_byte(k, 8'($urandom_range(0, 255)), 1'(b == len - 1));
                end
                if (hold_cnt[k] > 0)                 hold_cnt[k]--;
                else if ($urandom_range(0, 499) == 0) hold_cnt[k] = 70;
                else if ($urandom_range(0, 31) == 0)  hold_cnt[k] = $urandom_range(1, 12);
                hold[k] = (hold_cnt[k] > 0);
            end
            drive_inputs();
            step();
        end
        drain("rand", 20000);
        for (int k = 0; k < N; k++) check("rand_stream_left", xs[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
